master_link_xcvr: RTL and testbench
===================================

Name: master_link_xcvr

Overview:
- Master-side end of the two-wire serial link (signal line plus bitstream line) used to exchange game words with the slave board.
- Serializes a 16-bit word (the master's A value) onto ms_sig/ms_bs.
- Deserializes the slave's 16-bit B_Attack frame arriving on sm_sig/sm_bs.
- Sits between master game logic and the inter-board pins; both directions run independently on the master clock.

Parameters:
WIDTH, 16, bits per frame (data only)
BIT_CLKS, 100, clk cycles each bit (and lead/trail slot) is held; must be >= 4 and even

Ports:
clk  input  1  master clock; also the clock driven to the slave
clr  input  1  asynchronous, active-high reset
tx_data  input  WIDTH  word to send; latched on accepted tx_start
tx_start  input  1  one-cycle request to send tx_data
tx_busy  output  1  high from the cycle after acceptance until the frame incl. trail gap ends
tx_done  output  1  one-cycle pulse when the transmitter returns to IDLE
ms_sig  output  1  master->slave frame-active line
ms_bs  output  1  master->slave bitstream
sm_sig  input  1  slave->master frame-active line (asynchronous to us)
sm_bs  input  1  slave->master bitstream
rx_data  output  WIDTH  last correctly received word; held until the next good frame
rx_valid  output  1  one-cycle pulse when rx_data updates
rx_err  output  1  one-cycle pulse on an aborted receive frame

Behaviour:
- Reset (clr high, async): tx state IDLE, rx state IDLE; all counters and shift registers 0; all outputs 0, including rx_data.
- Wire format: idle ms_sig=0, ms_bs=0. Frame = LEAD slot (sig=1, bs=0), then WIDTH data slots LSB first (sig=1, bs=bit), then TRAIL slot (sig=0, bs=0). Every slot is exactly BIT_CLKS cycles.
- TX FSM, states IDLE -> LEAD -> DATA -> TRAIL -> IDLE:
  - tx_start in IDLE: latch tx_data into the shift register; enter LEAD next cycle. tx_busy and ms_sig rise in that same cycle.
  - DATA advances a bit index 0..WIDTH-1, shifting right every BIT_CLKS cycles.
  - TRAIL: ms_sig=0, tx_busy stays 1.
  - On TRAIL end, return to IDLE; tx_done pulses in the first IDLE cycle and tx_busy drops in that cycle.
  - tx_busy high for exactly (WIDTH+2)*BIT_CLKS cycles.
- tx_start while busy is ignored; no queueing. tx_start in the tx_done cycle is accepted normally.
- tx_data changes after acceptance have no effect on the frame in flight.
- RX synchronization: sm_sig and sm_bs each pass through a 2-flop synchronizer. All RX decisions use the synced values; latency from pin is 2 cycles.
- RX FSM, states IDLE -> LEAD -> DATA -> WAIT_LOW -> IDLE:
  - IDLE: a synced-sig rising edge (prev 0, now 1) enters LEAD with the counter cleared.
  - LEAD: wait BIT_CLKS cycles.
  - DATA: sample synced bs when the in-slot counter equals BIT_CLKS/2 (mid-bit); shift into an LSB-first register.
  - After the WIDTH-th sample, load rx_data and pulse rx_valid the next cycle, then enter WAIT_LOW.
  - WAIT_LOW: return to IDLE on synced sig = 0. A new frame is recognized only after sig has been low at least 1 cycle.
- Early drop: synced sig falling to 0 in LEAD or DATA before the WIDTH-th sample pulses rx_err for 1 cycle and returns to IDLE. rx_data is unchanged and rx_valid does not pulse.
- Sig held high indefinitely stays in WAIT_LOW; no error.
- TX and RX are fully independent; simultaneous activity is legal.
- clr mid-frame: both FSMs abort immediately. ms_sig drops, so the slave receiver sees an early drop.

Decomposition:
- Shared package (link_pkg):
  - tx_state_t and rx_state_t enums.
  - Default WIDTH/BIT_CLKS constants.
  - Slot-count helper constant MID = BIT_CLKS/2.
- Sub-module: link_sync2 (2-flop synchronizer, clk/clr, 1-bit), instantiated twice.
- TX and RX FSMs live in master_link_xcvr.

Test Plan (BIT_CLKS=4, WIDTH=16):
1. Reset then idle: clr pulse, 20 cycles -> all outputs 0; ms_sig stays 0.
2. TX 16'hA5C3: tx_start 1 cycle -> ms_sig high 68 cycles, then ms_bs per 4-cycle slot = 0 (lead), 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. tx_busy high 72 cycles; tx_done pulses once; a second tx_start at busy cycle 10 is ignored.
3. RX 16'h1234 from a bench driver in the same format -> rx_valid pulses once, rx_data=16'h1234 within 2+4+64+2 cycles of the sig rise.
4. RX abort: drive 16'hFFFF frame, drop sm_sig after 5 data slots -> rx_err pulses once; rx_data keeps the prior 16'h1234; no rx_valid.
5. Full duplex plus loopback: ms_* wired to sm_*, tx 16'h0001 while an external frame is also in progress -> rx_data=16'h0001; tx_done and rx_valid both pulse.
6. clr asserted mid-TX data slot 7 -> ms_sig=0 and tx_busy=0 immediately (async). A fresh tx_start after release sends a complete frame.

Source files
------------

// File: rtl/link_pkg.sv
// Shared types and defaults for the master/slave two-wire serial link.
package link_pkg;

    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_BIT_CLKS = 100;
    localparam int unsigned MID          = DEF_BIT_CLKS / 2;

    typedef enum logic [1:0] {TxIdle, TxLead, TxData, TxTrail} tx_state_t;
    typedef enum logic [1:0] {RxIdle, RxLead, RxData, RxWaitLow} rx_state_t;

endpackage

// File: rtl/link_sync2.sv
// Two-flop synchronizer for one asynchronous link input.
module link_sync2 (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/master_link_xcvr.sv
// Master end of the link: serializes tx_data onto ms_sig/ms_bs and
// deserializes the slave's frame arriving on sm_sig/sm_bs.
module master_link_xcvr
    import link_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned BIT_CLKS = DEF_BIT_CLKS
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_start,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             ms_sig,
    output logic             ms_bs,
    input  logic             sm_sig,
    input  logic             sm_bs,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_err
);

    localparam int unsigned CW = $clog2(BIT_CLKS);
    localparam int unsigned IW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(BIT_CLKS / 2);
    localparam logic [IW-1:0] BIT_LAST = IW'(WIDTH - 1);

    tx_state_t        tx_state;
    logic [CW-1:0]    tx_cnt;
    logic [IW-1:0]    tx_idx;
    logic [WIDTH-1:0] tx_shreg;

    rx_state_t        rx_state;
    logic [CW-1:0]    rx_cnt;
    logic [IW-1:0]    rx_idx;
    logic [WIDTH-1:0] rx_shreg;
    logic [WIDTH-1:0] rx_next;
    logic             sig_s;
    logic             bs_s;
    logic             sig_prev;

    link_sync2 u_sync_sig (.clk(clk), .clr(clr), .d(sm_sig), .q(sig_s));
    link_sync2 u_sync_bs  (.clk(clk), .clr(clr), .d(sm_bs),  .q(bs_s));

    assign rx_next = {bs_s, rx_shreg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tx_state <= TxIdle;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shreg <= '0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            ms_sig   <= 1'b0;
            ms_bs    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (tx_state)
                TxIdle: begin
                    if (tx_start) begin
                        tx_shreg <= tx_data;
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b1;
                        ms_sig   <= 1'b1;
                        ms_bs    <= 1'b0;
                        tx_state <= TxLead;
                    end
                end
                TxLead: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        ms_bs    <= tx_shreg[0];
                        tx_shreg <= tx_shreg >> 1;
                        tx_state <= TxData;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TxData: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == BIT_LAST) begin
                            ms_sig   <= 1'b0;
                            ms_bs    <= 1'b0;
                            tx_state <= TxTrail;
                        end else begin
                            tx_idx   <= tx_idx + IW'(1);
                            ms_bs    <= tx_shreg[0];
                            tx_shreg <= tx_shreg >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TxTrail: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                        tx_done  <= 1'b1;
                        tx_state <= TxIdle;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: tx_state <= TxIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rx_state <= RxIdle;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shreg <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            sig_prev <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            sig_prev <= sig_s;
            unique case (rx_state)
                RxIdle: begin
                    if (sig_s && !sig_prev) begin
                        rx_cnt   <= '0;
                        rx_state <= RxLead;
                    end
                end
                RxLead: begin
                    if (!sig_s) begin
                        rx_err   <= 1'b1;
                        rx_state <= RxIdle;
                    end else if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= RxData;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RxData: begin
                    if (!sig_s) begin
                        rx_err   <= 1'b1;
                        rx_state <= RxIdle;
                    end else begin
                        // Mid-slot sample keeps margin on both sides of the bit
                        if (rx_cnt == CNT_MID) begin
                            rx_shreg <= rx_next;
                            if (rx_idx == BIT_LAST) begin
                                rx_data  <= rx_next;
                                rx_valid <= 1'b1;
                                rx_state <= RxWaitLow;
                            end
                        end
                        if (rx_cnt == CNT_LAST) begin
                            rx_cnt <= '0;
                            rx_idx <= rx_idx + IW'(1);
                        end else begin
                            rx_cnt <= rx_cnt + CW'(1);
                        end
                    end
                end
                RxWaitLow: begin
                    if (!sig_s) begin
                        rx_state <= RxIdle;
                    end
                end
                default: rx_state <= RxIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_master_link_xcvr.sv
// Bench for master_link_xcvr with BIT_CLKS=4, WIDTH=16.
module tb_master_link_xcvr;

    localparam int W     = 16;
    localparam int BC    = 4;
    localparam int FRAME = (W + 2) * BC;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic [W-1:0] tx_data = '0;
    logic         tx_start = 1'b0;
    logic         tx_busy, tx_done, ms_sig, ms_bs;
    logic         sm_sig, sm_bs;
    logic [W-1:0] rx_data;
    logic         rx_valid, rx_err;
    logic         drv_sig = 1'b0;
    logic         drv_bs = 1'b0;
    logic         loop = 1'b0;

    assign sm_sig = loop ? ms_sig : drv_sig;
    assign sm_bs  = loop ? ms_bs  : drv_bs;

    always #5 clk = ~clk;

    master_link_xcvr #(.WIDTH(W), .BIT_CLKS(BC)) dut (
        .clk      (clk),
        .clr      (clr),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .ms_sig   (ms_sig),
        .ms_bs    (ms_bs),
        .sm_sig   (sm_sig),
        .sm_bs    (sm_bs),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int last_valid_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
        if (rx_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // {tx_busy, ms_sig, ms_bs} expected i cycles after the accepting edge
    function automatic logic [2:0] tx_model(input logic [W-1:0] word, input int i);
        if (i < BC) return 3'b110;
        if (i < (W + 1) * BC) return {2'b11, word[(i - BC) / BC]};
        if (i < FRAME) return 3'b100;
        return 3'b000;
    endfunction

    // Caller has already raised tx_start with tx_data=word away from the edge.
    task automatic run_tx(input logic [W-1:0] word, input bit poke, input bit chain,
                          input logic [W-1:0] nxt);
        @(posedge clk);
        #1 tx_start = 1'b0;
        for (int i = 0; i <= FRAME; i++) begin
            @(negedge clk);
            check("tx_wave", {29'd0, tx_busy, ms_sig, ms_bs}, {29'd0, tx_model(word, i)});
            check("tx_done", {31'd0, tx_done}, {31'd0, (i == FRAME)});
            if (poke && i == 10) begin
                tx_start = 1'b1;
                tx_data  = ~word;
            end
            if (poke && i == 11) begin
                tx_start = 1'b0;
                tx_data  = W'($urandom);
            end
            if (chain && i == FRAME) begin
                tx_start = 1'b1;
                tx_data  = nxt;
            end
        end
        if (!chain) begin
            @(negedge clk);
            check("tx_done_once", {31'd0, tx_done}, 32'd0);
        end
    endtask

    task automatic start_tx(input logic [W-1:0] word, input bit poke);
        tx_data  = word;
        tx_start = 1'b1;
        run_tx(word, poke, 1'b0, '0);
    endtask

    // Drives a slave frame; slots < W drops sig after that many data slots.
    task automatic drive_rx(input logic [W-1:0] word, input int slots, output int rise_cyc);
        @(posedge clk);
        #1;
        drv_sig  = 1'b1;
        drv_bs   = 1'b0;
        rise_cyc = cyc;
        for (int k = 0; k < slots; k++) begin
            repeat (BC) @(posedge clk);
            #1 drv_bs = word[k];
        end
        repeat (BC) @(posedge clk);
        #1;
        drv_sig = 1'b0;
        drv_bs  = 1'b0;
        repeat (BC) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] tx_word;
        logic [W-1:0] rx_word;
        int           rx_slots;
        logic         exp_valid;
        logic         exp_err;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t         vecs[4];
    logic [W-1:0] model_rx;
    int           rise;
    int           v0, e0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'hA5C3, 16'h1234, 16, 1'b1, 1'b0, 16'h1234};
        vecs[1] = '{16'h0000, 16'hFFFF,  5, 1'b0, 1'b1, 16'h1234};
        vecs[2] = '{16'hFFFF, 16'h8001, 16, 1'b1, 1'b0, 16'h8001};
        vecs[3] = '{16'h5A5A, 16'h0F0F,  0, 1'b0, 1'b1, 16'h8001};
        model_rx = '0;

        repeat (2) @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_idle", {10'd0, tx_busy, tx_done, ms_sig, ms_bs, rx_valid, rx_err, rx_data},
                  32'd0);
        end

        for (int i = 0; i < 4; i++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            fork
                start_tx(vecs[i].tx_word, (i == 0));
                drive_rx(vecs[i].rx_word, vecs[i].rx_slots, rise);
            join
            repeat (6) @(negedge clk);
            check("vec_rx_valid", valid_cnt - v0, {31'd0, vecs[i].exp_valid});
            check("vec_rx_err", err_cnt - e0, {31'd0, vecs[i].exp_err});
            check("vec_rx_data", {16'd0, rx_data}, {16'd0, vecs[i].exp_data});
            if (vecs[i].exp_valid)
                check("vec_rx_latency_le72", {31'd0, (last_valid_cyc - rise <= 72)}, 32'd1);
            model_rx = vecs[i].exp_data;
        end

        // Back-to-back: start in the tx_done cycle is accepted
        tx_data  = 16'h3C96;
        tx_start = 1'b1;
        run_tx(16'h3C96, 1'b0, 1'b1, 16'hC369);
        run_tx(16'hC369, 1'b0, 1'b0, '0);

        loop = 1'b1;
        v0 = valid_cnt;
        e0 = err_cnt;
        start_tx(16'h0001, 1'b0);
        repeat (6) @(negedge clk);
        check("loop_rx_valid", valid_cnt - v0, 32'd1);
        check("loop_rx_err", err_cnt - e0, 32'd0);
        check("loop_rx_data", {16'd0, rx_data}, 32'h0001);
        model_rx = 16'h0001;
        loop = 1'b0;

        for (int n = 0; n < 6; n++) begin
            logic [W-1:0] tw, rw;
            int           slots;
            tw    = W'($urandom);
            rw    = W'($urandom);
            slots = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : W;
            v0 = valid_cnt;
            e0 = err_cnt;
            fork
                start_tx(tw, 1'b0);
                drive_rx(rw, slots, rise);
            join
            repeat (6) @(negedge clk);
            if (slots == W) model_rx = rw;
            check("rnd_rx_valid", valid_cnt - v0, {31'd0, (slots == W)});
            check("rnd_rx_err", err_cnt - e0, {31'd0, (slots != W)});
            check("rnd_rx_data", {16'd0, rx_data}, {16'd0, model_rx});
        end

        // Reset in the middle of data slot 7
        tx_data  = 16'hBEEF;
        tx_start = 1'b1;
        @(posedge clk);
        #1 tx_start = 1'b0;
        repeat (BC + 7 * BC + 1) @(posedge clk);
        @(negedge clk);
        check("pre_clr_busy", {31'd0, tx_busy}, 32'd1);
        clr = 1'b1;
        #1;
        check("clr_ms_sig", {31'd0, ms_sig}, 32'd0);
        check("clr_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("clr_rx_data", {16'd0, rx_data}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        model_rx = '0;
        @(negedge clk);
        start_tx(W'($urandom), 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
